// File: rtl/memory_arbiter_if.sv
// Datapath-to-RAM bus seen by the memory arbiter: requests and hits on the cache side,
// enables/address/data on the RAM side. slave = arbiter view, master = datapath/RAM view.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic [31:0] iload;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data load/store. Data has fixed
// priority; the granted address/store/op are latched so the RAM sees stable signals.
module memory_arbiter #(
  parameter int unsigned TIMEOUT       = 15,
  parameter bit          PC_WORD_ALIGN = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  memory_arbiter_if.slave   bus,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DACC  = 2'd1,
    IACC  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [7:0]  TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [31:0] ADDR_MASK  = PC_WORD_ALIGN ? 32'hFFFF_FFFC : 32'hFFFF_FFFF;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic        write_q;
  logic [7:0]  cnt_q;
  logic        err_q;

  logic        d_req;
  assign d_req = bus.dREN | bus.dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (d_req) begin
            state_q <= DACC;
            addr_q  <= bus.daddr & ADDR_MASK;
            store_q <= bus.dstore;
            write_q <= bus.dWEN;
          end else if (bus.iREN) begin
            state_q <= IACC;
            addr_q  <= bus.iaddr & ADDR_MASK;
            store_q <= bus.dstore;
            write_q <= 1'b0;
          end
        end
        DACC, IACC: begin
          // The RAM access always runs to ramready even if the requester withdrew.
          if (bus.ramready) begin
            state_q <= IDLE;
          end else if (cnt_q == TIMEOUT_C) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ERROR: begin
          err_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic        ihit_c;
  logic        dhit_c;
  logic        ram_ren_c;
  logic        ram_wen_c;
  logic [31:0] ram_addr_c;
  logic [31:0] ram_store_c;
  logic [31:0] iload_c;
  logic [31:0] dload_c;

  // Hits complete combinationally in the ramready cycle; a dropped request masks its hit.
  always_comb begin
    ihit_c      = 1'b0;
    dhit_c      = 1'b0;
    ram_ren_c   = 1'b0;
    ram_wen_c   = 1'b0;
    ram_addr_c  = '0;
    ram_store_c = '0;
    iload_c     = '0;
    dload_c     = '0;
    case (state_q)
      DACC: begin
        ram_ren_c   = !write_q;
        ram_wen_c   = write_q;
        ram_addr_c  = addr_q;
        ram_store_c = store_q;
        dhit_c      = bus.ramready & d_req;
        if (dhit_c && !write_q) dload_c = bus.ramload;
      end
      IACC: begin
        ram_ren_c  = 1'b1;
        ram_addr_c = addr_q;
        ihit_c     = bus.ramready & bus.iREN;
        if (ihit_c) iload_c = bus.ramload;
      end
      default: begin
      end
    endcase
  end

  assign bus.ihit     = ihit_c;
  assign bus.dhit     = dhit_c;
  assign bus.iload    = iload_c;
  assign bus.dload    = dload_c;
  assign bus.ramREN   = ram_ren_c;
  assign bus.ramWEN   = ram_wen_c;
  assign bus.ramaddr  = ram_addr_c;
  assign bus.ramstore = ram_store_c;
  assign bus.err      = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios with literal expectations, plus a
// transaction-level model compared against every output on each falling edge.
module tb_memory_arbiter;

  localparam int TO = 15;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [1:0] dbg_state;

  memory_arbiter_if bus();

  memory_arbiter #(.TIMEOUT(TO), .PC_WORD_ALIGN(1'b1)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int ihit_seen = 0;
  int dhit_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: at most one outstanding grant ----------------
  typedef struct packed {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] store;
    logic [7:0]  stalls;
  } grant_t;

  grant_t grant_q[$];
  bit     m_dead = 1'b0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grant_q.delete();
      m_dead = 1'b0;
    end else if (!m_dead) begin
      if (grant_q.size() == 0) begin
        if (bus.dREN || bus.dWEN)
          grant_q.push_back({1'b1, bus.dWEN, bus.daddr & 32'hFFFF_FFFC, bus.dstore, 8'd0});
        else if (bus.iREN)
          grant_q.push_back({1'b0, 1'b0, bus.iaddr & 32'hFFFF_FFFC, 32'd0, 8'd0});
      end else if (bus.ramready) begin
        grant_q.delete();
      end else begin
        // An access dies on its (TO+1)th consecutive cycle without ramready.
        grant_q[0].stalls = grant_q[0].stalls + 8'd1;
        if (int'(grant_q[0].stalls) > TO) begin
          grant_q.delete();
          m_dead = 1'b1;
        end
      end
    end
  end

  grant_t g;
  bit     busy;
  logic   e_dhit, e_ihit;

  always @(negedge CLK) begin
    busy = (grant_q.size() != 0);
    g    = busy ? grant_q[0] : '0;
    e_dhit = busy && g.is_d && bus.ramready && (bus.dREN || bus.dWEN);
    e_ihit = busy && !g.is_d && bus.ramready && bus.iREN;
    check("m_ramREN",   {31'd0, bus.ramREN}, {31'd0, busy && !(g.is_d && g.wr)});
    check("m_ramWEN",   {31'd0, bus.ramWEN}, {31'd0, busy && g.is_d && g.wr});
    check("m_ramaddr",  bus.ramaddr,  busy ? g.addr : 32'd0);
    check("m_ramstore", bus.ramstore, (busy && g.is_d) ? g.store : 32'd0);
    check("m_dhit",     {31'd0, bus.dhit}, {31'd0, e_dhit});
    check("m_ihit",     {31'd0, bus.ihit}, {31'd0, e_ihit});
    check("m_dload",    bus.dload, (e_dhit && !g.wr) ? bus.ramload : 32'd0);
    check("m_iload",    bus.iload, e_ihit ? bus.ramload : 32'd0);
    check("m_err",      {31'd0, bus.err}, {31'd0, m_dead});
    if (bus.ihit) ihit_seen++;
    if (bus.dhit) dhit_seen++;
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramready = 1'b0;
  endtask

  int ih0;
  int dh0;

  initial begin
    idle_inputs();
    #2;
    check("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_hits", {30'd0, bus.ihit, bus.dhit}, 32'd0);
    tick(); tick();
    nRST = 1'b1;
    tick();

    // Instruction fetch, ramready on the second access cycle.
    ih0 = ihit_seen;
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0104;
    tick();
    @(negedge CLK);
    check("fetch_ren_c1", {31'd0, bus.ramREN}, 32'd1);
    check("fetch_addr_c1", bus.ramaddr, 32'h0000_0104);
    tick();
    bus.ramready = 1'b1; bus.ramload = 32'h00A0_0093;
    @(negedge CLK);
    check("fetch_ihit", {31'd0, bus.ihit}, 32'd1);
    check("fetch_iload", bus.iload, 32'h00A0_0093);
    tick();
    idle_inputs();
    @(negedge CLK);
    check("fetch_idle_ren", {31'd0, bus.ramREN}, 32'd0);
    check("fetch_ihit_count", ihit_seen - ih0, 32'd1);

    // Simultaneous requests: data first, one idle cycle, then instruction.
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0104;
    bus.dREN = 1'b1; bus.daddr = 32'h0000_0200;
    bus.ramready = 1'b1; bus.ramload = 32'h1111_2222;
    tick();
    @(negedge CLK);
    check("sim_daddr", bus.ramaddr, 32'h0000_0200);
    check("sim_dhit", {31'd0, bus.dhit}, 32'd1);
    check("sim_dload", bus.dload, 32'h1111_2222);
    tick();
    bus.dREN = 1'b0;
    @(negedge CLK);
    check("sim_gap_ren", {31'd0, bus.ramREN}, 32'd0);
    check("sim_gap_ihit", {31'd0, bus.ihit}, 32'd0);
    tick();
    @(negedge CLK);
    check("sim_ihit", {31'd0, bus.ihit}, 32'd1);
    check("sim_iaddr", bus.ramaddr, 32'h0000_0104);
    tick();
    idle_inputs();
    tick();

    // Store with daddr changing after the grant.
    dh0 = dhit_seen;
    bus.dWEN = 1'b1; bus.daddr = 32'h0000_03F0; bus.dstore = 32'hDEAD_BEEF;
    bus.ramload = 32'h0000_0055;
    tick();
    bus.daddr = 32'h0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("st_wen", {31'd0, bus.ramWEN}, 32'd1);
      check("st_addr", bus.ramaddr, 32'h0000_03F0);
      check("st_store", bus.ramstore, 32'hDEAD_BEEF);
      tick();
    end
    bus.ramready = 1'b1;
    @(negedge CLK);
    check("st_dhit", {31'd0, bus.dhit}, 32'd1);
    check("st_dload", bus.dload, 32'd0);
    check("st_addr_end", bus.ramaddr, 32'h0000_03F0);
    tick();
    idle_inputs();
    tick();
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h0000_0010; bus.dstore = 32'h0BAD_F00D;
    tick();
    bus.ramready = 1'b1;
    @(negedge CLK);
    check("rw_wen", {31'd0, bus.ramWEN}, 32'd1);
    check("rw_ren", {31'd0, bus.ramREN}, 32'd0);
    check("rw_dhit", {31'd0, bus.dhit}, 32'd1);
    tick();
    idle_inputs();
    check("st_dhit_count", dhit_seen - dh0, 32'd2);
    tick();

    // Withdrawal: dREN dropped mid-access; a waiting unaligned fetch follows.
    dh0 = dhit_seen;
    bus.dREN = 1'b1; bus.daddr = 32'h0000_0040;
    tick();
    bus.dREN = 1'b0; bus.iREN = 1'b1; bus.iaddr = 32'h0000_0083;
    @(negedge CLK);
    check("wd_ren", {31'd0, bus.ramREN}, 32'd1);
    check("wd_addr", bus.ramaddr, 32'h0000_0040);
    tick();
    bus.ramready = 1'b1; bus.ramload = 32'h7777_7777;
    @(negedge CLK);
    check("wd_no_dhit", {31'd0, bus.dhit}, 32'd0);
    tick();
    bus.ramready = 1'b0;
    @(negedge CLK);
    check("wd_idle", {31'd0, bus.ramREN}, 32'd0);
    tick();
    bus.ramready = 1'b1; bus.ramload = 32'h0000_0013;
    @(negedge CLK);
    check("wd_iaddr_aligned", bus.ramaddr, 32'h0000_0080);
    check("wd_ihit", {31'd0, bus.ihit}, 32'd1);
    check("wd_dhit_count", dhit_seen - dh0, 32'd0);
    tick();
    idle_inputs();
    tick();

    // Timeout: err must appear in the 17th cycle after the grant edge.
    ih0 = ihit_seen;
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0008;
    tick();
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      check("to_err_low", {31'd0, bus.err}, 32'd0);
      tick();
    end
    @(negedge CLK);
    check("to_err_high", {31'd0, bus.err}, 32'd1);
    check("to_ren_off", {31'd0, bus.ramREN}, 32'd0);
    tick();
    bus.ramready = 1'b1; bus.ramload = 32'h1234_5678;
    @(negedge CLK);
    check("to_no_ihit", {31'd0, bus.ihit}, 32'd0);
    check("to_ihit_count", ihit_seen - ih0, 32'd0);
    tick();
    bus.ramready = 1'b0;
    #1;
    nRST = 1'b0;
    #1;
    check("to_rst_err", {31'd0, bus.err}, 32'd0);
    check("to_rst_ren", {31'd0, bus.ramREN}, 32'd0);
    idle_inputs();
    tick();
    nRST = 1'b1;
    tick();

    // Reset in the middle of a store.
    bus.dWEN = 1'b1; bus.daddr = 32'h0000_0500; bus.dstore = 32'hCAFE_0001;
    tick();
    check("mr_wen_before", {31'd0, bus.ramWEN}, 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    check("mr_wen_async", {31'd0, bus.ramWEN}, 32'd0);
    check("mr_addr_async", bus.ramaddr, 32'd0);
    idle_inputs();
    tick();
    nRST = 1'b1;
    tick();
    bus.iREN = 1'b1; bus.iaddr = 32'h0; bus.ramready = 1'b1; bus.ramload = 32'h0000_0013;
    tick();
    @(negedge CLK);
    check("mr_fetch_addr", bus.ramaddr, 32'h0);
    check("mr_fetch_ihit", {31'd0, bus.ihit}, 32'd1);
    check("mr_fetch_iload", bus.iload, 32'h0000_0013);
    tick();
    idle_inputs();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sequences the single shared RAM port between the datapath's instruction-fetch request and its data load/store request.
- Sits between the datapath cache interface (imem*/dmem* signals) and the RAM.
- Grants one requester at a time and latches that requester's address and store data, so the RAM sees stable signals.
- Returns per-requester hit pulses and load data, and flags a RAM timeout as a sticky error.

Parameters:
- TIMEOUT, 15: maximum cycles spent in an access state without ramready before entering ERROR; legal range 1..255.
- PC_WORD_ALIGN, 1: when 1, address bits [1:0] are forced to 0 on both latched addresses.

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  instruction read request (imemREN)
- iaddr  input  32  instruction address (imemaddr)
- dREN  input  1  data read request (dmemREN)
- dWEN  input  1  data write request (dmemWEN)
- daddr  input  32  data address (dmemaddr)
- dstore  input  32  data to write (dmemstore)
- ihit  output  1  instruction access complete, one-cycle pulse
- iload  output  32  instruction word, valid when ihit=1
- dhit  output  1  data access complete, one-cycle pulse
- dload  output  32  load data, valid when dhit=1 on a read
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data, valid with ramready
- ramready  input  1  RAM access complete this cycle
- err  output  1  sticky timeout error

Behaviour:
- Reset is asynchronous, active-low, on nRST, with clock CLK. On reset:
  - state=IDLE; latched addr/store/op = 0; timeout counter = 0; err=0.
  - All outputs 0: ihit, dhit, ramREN, ramWEN, ramaddr, ramstore, iload, dload.
- States: IDLE, DACC, IACC, ERROR.
- IDLE:
  - RAM enables are 0.
  - Arbitration: data has fixed priority. If (dREN|dWEN) go to DACC, else if iREN go to IACC, else stay.
  - On a grant, latch on the same edge: address (daddr or iaddr, with [1:0] cleared if PC_WORD_ALIGN); dstore; op.
  - Op: write if dWEN=1. Write wins when dREN and dWEN are both 1.
  - Clear the counter.
- DACC:
  - ramaddr and ramstore are driven from the latches.
  - ramWEN = latched write; ramREN = !latched write.
- IACC:
  - ramREN=1, ramWEN=0, ramaddr from the latch, ramstore=0.
- Completion (DACC/IACC, combinational in the ramready cycle):
  - In DACC: dhit = ramready & (dREN|dWEN).
  - In IACC: ihit = ramready & iREN.
  - dload/iload = ramload in that cycle, otherwise 0.
  - Next state is IDLE. The arbiter never chains grants: the requester's new address becomes valid only after the hit edge.
- Withdrawal: if a requester drops its request mid-access, the RAM access still runs to ramready, the hit is suppressed, and the FSM returns to IDLE.
- Minimum latency: request in cycle n, RAM driven in cycle n+1, hit in cycle n+1 if ramready. Back-to-back grants have at least one IDLE cycle between them.
- Timeout:
  - The counter increments in each DACC/IACC cycle without ramready.
  - When the counter equals TIMEOUT in an access state without ramready, go to ERROR.
  - ERROR is absorbing until reset: err=1, RAM enables 0, hits 0.
- Requests arriving during an access are ignored until IDLE. A pending iREN waits while data requests keep winning; the datapath guarantees data requests end.
- Inputs are not registered except at grant. Changes to daddr/iaddr/dstore during an access do not affect the RAM signals.

Test Plan:
- Instruction fetch: iREN=1, iaddr=0x00000104; ramready 2 cycles after grant with ramload=0x00A00093. Expect:
  - ramREN=1, ramaddr=0x104 for those cycles.
  - ihit pulses exactly once with iload=0x00A00093.
  - Then IDLE for one cycle.
- Simultaneous requests: iREN=1, dREN=1, daddr=0x200, ramready immediate. Expect:
  - DACC first: ramaddr=0x200, dhit pulse.
  - One IDLE cycle.
  - IACC: ihit pulse.
- Store: dWEN=1, daddr=0x3F0, dstore=0xDEADBEEF. Change daddr to 0x0 one cycle after the grant; ramready after 3 cycles. Expect:
  - ramWEN=1, ramaddr stays 0x3F0, ramstore=0xDEADBEEF throughout.
  - dhit=1, dload=0.
  - With dREN=dWEN=1, expect ramWEN=1, ramREN=0.
- Withdrawal: dREN=1, grant, then drop dREN before ramready. Expect dhit stays 0, FSM returns to IDLE after ramready, and the next iREN is served.
- Timeout: TIMEOUT=15, iREN=1, ramready held 0. Expect:
  - err rises 16 cycles after the grant.
  - RAM enables 0; no hits even if ramready later pulses.
  - nRST low clears err and all outputs asynchronously.
- Reset mid-access: assert nRST low during DACC with ramWEN=1. Expect ramWEN drops immediately without a clock edge, and a post-reset fetch from 0x0 succeeds.
